// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned SADD_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sadd_state_t;

endpackage

// File: rtl/serial_adder_seq_if.sv
// Operand/result handshake bundle for serial_adder_seq.
interface serial_adder_seq_if #(
    parameter int unsigned WIDTH = serial_adder_pkg::SADD_DEFAULT_WIDTH
);
    logic             Start_SI;
    logic [WIDTH-1:0] A_DI;
    logic [WIDTH-1:0] B_DI;
    logic             Cin_DI;
    logic             Ready_SO;
    logic             Done_SO;
    logic [WIDTH-1:0] Sum_DO;
    logic             Cout_DO;

    modport master (
        output Start_SI, A_DI, B_DI, Cin_DI,
        input  Ready_SO, Done_SO, Sum_DO, Cout_DO
    );

    modport slave (
        input  Start_SI, A_DI, B_DI, Cin_DI,
        output Ready_SO, Done_SO, Sum_DO, Cout_DO
    );
endinterface

// File: rtl/fulladder_dataflow.sv
// 1-bit full adder cell, pure dataflow.
module fulladder_dataflow (
    input  logic A_DI,
    input  logic B_DI,
    input  logic Cin_DI,
    output logic S_DO,
    output logic C_DO
);
    assign S_DO = A_DI ^ B_DI ^ Cin_DI;
    assign C_DO = (A_DI & B_DI) | (Cin_DI & (A_DI ^ B_DI));
endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: feeds one operand bit pair per cycle, LSB first,
// into a single full-adder cell and collects the sum into a parallel result.
module serial_adder_seq
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SADD_DEFAULT_WIDTH
) (
    input logic               Clk_CI,
    input logic               Rst_RI,
    serial_adder_seq_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    sadd_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
    logic [WIDTH:0]   sum_ins;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic             fa_s, fa_c;
    logic             accept, shift_en, ready, done;

    fulladder_dataflow u_fa (
        .A_DI   (a_sh_q[0]),
        .B_DI   (b_sh_q[0]),
        .Cin_DI (carry_q),
        .S_DO   (fa_s),
        .C_DO   (fa_c)
    );

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.Start_SI) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // New sum bit enters at the MSB; after WIDTH shifts the result is LSB-aligned.
    assign sum_ins = {fa_s, sum_q};

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sh_q  <= bus.A_DI;
            b_sh_q  <= bus.B_DI;
            carry_q <= bus.Cin_DI;
            cnt_q   <= '0;
        end else if (shift_en) begin
            a_sh_q  <= a_sh_q >> 1;
            b_sh_q  <= b_sh_q >> 1;
            sum_q   <= sum_ins[WIDTH:1];
            carry_q <= fa_c;
            cnt_q   <= cnt_q + CntW'(1);
        end
    end

    assign bus.Ready_SO = ready;
    assign bus.Done_SO  = done;
    assign bus.Sum_DO   = sum_q;
    assign bus.Cout_DO  = carry_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq at WIDTH=8 and WIDTH=1.
module tb_serial_adder_seq;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_seq_if #(.WIDTH(8)) bus8 ();
    serial_adder_seq_if #(.WIDTH(1)) bus1 ();

    serial_adder_seq #(.WIDTH(8)) dut8 (
        .Clk_CI (clk),
        .Rst_RI (rst),
        .bus    (bus8.slave)
    );

    serial_adder_seq #(.WIDTH(1)) dut1 (
        .Clk_CI (clk),
        .Rst_RI (rst),
        .bus    (bus1.slave)
    );

    exp_t       q8[$];
    exp_t       q1[$];
    exp_t       e8, e1;
    logic       done8_prev = 1'b0;
    logic       done1_prev = 1'b0;
    logic       hold8 = 1'b0;
    logic [7:0] held_sum8;
    logic       held_cout8;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for the 8-bit instance: pops on every Done pulse, then watches the hold.
    always @(negedge clk) begin
        if (bus8.Done_SO) begin
            check("done8_single", 32'(done8_prev), 32'(0));
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected: Done_SO high with no outstanding op (cycle %0d)",
                         cyc);
            end else begin
                e8 = q8.pop_front();
                check("sum8", 32'(bus8.Sum_DO), 32'(e8.sum));
                check("cout8", 32'(bus8.Cout_DO), 32'(e8.cout));
                check("done8_cycle", 32'(cyc), 32'(e8.due));
            end
            hold8      = 1'b1;
            held_sum8  = bus8.Sum_DO;
            held_cout8 = bus8.Cout_DO;
        end else if (hold8) begin
            check("sum8_hold", 32'(bus8.Sum_DO), 32'(held_sum8));
            check("cout8_hold", 32'(bus8.Cout_DO), 32'(held_cout8));
        end
        done8_prev = bus8.Done_SO;
    end

    always @(negedge clk) begin
        if (bus1.Done_SO) begin
            check("done1_single", 32'(done1_prev), 32'(0));
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done1_unexpected: Done_SO high with no outstanding op (cycle %0d)",
                         cyc);
            end else begin
                e1 = q1.pop_front();
                check("sum1", 32'(bus1.Sum_DO), 32'(e1.sum[0]));
                check("cout1", 32'(bus1.Cout_DO), 32'(e1.cout));
                check("done1_cycle", 32'(cyc), 32'(e1.due));
            end
        end
        done1_prev = bus1.Done_SO;
    end

    task automatic wait_ready8();
        int n = 0;
        while (!bus8.Ready_SO && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready8_wait", 32'(bus8.Ready_SO), 32'(1));
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] es, input logic ec, input bit keep,
                          input bit expect_done);
        wait_ready8();
        bus8.A_DI     = a;
        bus8.B_DI     = b;
        bus8.Cin_DI   = cin;
        bus8.Start_SI = 1'b1;
        if (expect_done) q8.push_back('{es, ec, cyc + 1 + 8});
        @(posedge clk);
        hold8 = 1'b0;
        #1;
        if (!keep) bus8.Start_SI = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q8.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d results outstanding, expected 0/0",
                     q8.size(), q1.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // {a, b, cin} -> {cout, sum}
    logic [1:0] fa_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        bus8.Start_SI = 1'b0;
        bus8.A_DI     = '0;
        bus8.B_DI     = '0;
        bus8.Cin_DI   = 1'b0;
        bus1.Start_SI = 1'b0;
        bus1.A_DI     = '0;
        bus1.B_DI     = '0;
        bus1.Cin_DI   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_ready8", 32'(bus8.Ready_SO), 32'(1));
        check("rst_done8", 32'(bus8.Done_SO), 32'(0));
        check("rst_sum8", 32'(bus8.Sum_DO), 32'(0));
        check("rst_cout8", 32'(bus8.Cout_DO), 32'(0));
        check("rst_ready1", 32'(bus1.Ready_SO), 32'(1));
        check("rst_sum1", 32'(bus1.Sum_DO), 32'(0));

        issue8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
        check("ready8_busy", 32'(bus8.Ready_SO), 32'(0));
        drain();
        issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();
        issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        drain();

        // Start pulsed during SHIFT must be ignored.
        issue8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        bus8.A_DI     = 8'h01;
        bus8.B_DI     = 8'h01;
        bus8.Start_SI = 1'b1;
        @(negedge clk);
        bus8.Start_SI = 1'b0;
        check("ready8_ignored", 32'(bus8.Ready_SO), 32'(0));
        drain();
        repeat (12) @(negedge clk);

        // Reset at SHIFT count 4 aborts without a Done pulse.
        issue8(8'h5A, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst   = 1'b1;
        hold8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready8", 32'(bus8.Ready_SO), 32'(1));
        check("abort_done8", 32'(bus8.Done_SO), 32'(0));
        check("abort_sum8", 32'(bus8.Sum_DO), 32'(0));
        check("abort_cout8", 32'(bus8.Cout_DO), 32'(0));
        repeat (12) @(negedge clk);

        // Reset and Start on the same edge: Start is dropped.
        bus8.A_DI     = 8'hFF;
        bus8.B_DI     = 8'hFF;
        bus8.Cin_DI   = 1'b1;
        bus8.Start_SI = 1'b1;
        rst           = 1'b1;
        hold8         = 1'b0;
        @(negedge clk);
        rst           = 1'b0;
        bus8.Start_SI = 1'b0;
        check("rst_wins_ready8", 32'(bus8.Ready_SO), 32'(1));
        check("rst_wins_sum8", 32'(bus8.Sum_DO), 32'(0));
        repeat (12) @(negedge clk);

        // Back-to-back with Start held high: one result every 10 cycles.
        issue8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b1, 1'b1);
        issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        issue8(8'hC3, 8'h7E, 1'b0, 8'h41, 1'b1, 1'b0, 1'b1);
        drain();

        // WIDTH=1: full-adder truth table, Done one edge after acceptance.
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            logic [2:0] v;
            logic [1:0] r;
            v = 3'(i);
            r = fa_tab[i];
            while (!bus1.Ready_SO && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("ready1_wait", 32'(bus1.Ready_SO), 32'(1));
            bus1.A_DI     = v[2];
            bus1.B_DI     = v[1];
            bus1.Cin_DI   = v[0];
            bus1.Start_SI = 1'b1;
            q1.push_back('{{7'b0, r[0]}, r[1], cyc + 2});
            @(posedge clk);
            #1;
            bus1.Start_SI = 1'b0;
            @(negedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
